// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller: FSM state encoding,
// synchronizer depth and the counter-width helper.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } sar_state_e;

    localparam int SYNC_STAGES = 2;

    // Bits needed for a counter that runs 0 .. cycles-1 (never less than 1).
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Host-side conversion handshake of the SAR controller (start/busy/done/result).
interface sar_adc_ctrl_if #(
    parameter int N_BITS = 8
);
    // Handshake: start is sampled only when busy=0. Otherwise it is dropped,
    // not queued. busy covers the first SAMPLE cycle through DONE. done pulses
    // for one cycle, and result is valid from that cycle until the next done.
    logic              start;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    modport master (output start, input busy, input done, input result);
    modport slave  (input start, output busy, output done, output result);
endinterface

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator decision,
// with a synchronous active-high clear.
module cmp_sync
    import sar_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: one comparator decision per bit, MSB first.
// Define CMP_SYNC_EN to synchronize cmp_in and lengthen each settle window by 2.
module sar_adc_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmp_in,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output sar_state_e        state_dbg,
    sar_adc_ctrl_if.slave     host
);

`ifdef CMP_SYNC_EN
    localparam int SETTLE_EFF = SETTLE_CYCLES + SYNC_STAGES;
`else
    localparam int SETTLE_EFF = SETTLE_CYCLES;
`endif
    localparam int CW_SET = cnt_width(SETTLE_EFF);
    localparam int CW_SMP = cnt_width(SAMPLE_CYCLES);
    localparam int CNT_W  = (CW_SET > CW_SMP) ? CW_SET : CW_SMP;
    localparam int IDX_W  = $clog2(N_BITS);

    sar_state_e        state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [N_BITS-1:0] trial;
    logic [N_BITS-1:0] decided;
    logic [N_BITS-1:0] result_q;
    logic              cmp_d;

`ifdef CMP_SYNC_EN
    cmp_sync #(.STAGES(SYNC_STAGES)) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_d)
    );
`else
    // Only valid when the comparator itself is clocked from clk.
    assign cmp_d = cmp_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (host.start) next_state = SAMPLE;
            SAMPLE:  if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) next_state = SETTLE;
            SETTLE:  if (cnt == CNT_W'(SETTLE_EFF - 1)) next_state = DECIDE;
            DECIDE:  next_state = (bit_idx == '0) ? DONE : SETTLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sample      = (state == SAMPLE);
        host.busy   = (state != IDLE);
        host.done   = (state == DONE);
        host.result = result_q;
        dac_code    = trial;
        state_dbg   = state;
    end

    // The bit under test survives only if the input is at or above the trial level.
    always_comb begin
        decided = trial;
        if (!cmp_d) decided[bit_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            trial    <= '0;
            result_q <= '0;
        end else begin
            if ((state == SAMPLE || state == SETTLE) && next_state == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;

            case (state)
                SAMPLE: begin
                    if (next_state == SETTLE) begin
                        trial   <= N_BITS'(1) << (N_BITS - 1);
                        bit_idx <= IDX_W'(N_BITS - 1);
                    end
                end
                DECIDE: begin
                    if (bit_idx != '0) begin
                        trial   <= decided | (N_BITS'(1) << (bit_idx - 1'b1));
                        bit_idx <= bit_idx - 1'b1;
                    end else begin
                        result_q <= decided;
                        trial    <= '0;
                    end
                end
                SETTLE: ;
                default: trial <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed plus random checks of sar_adc_ctrl against an ideal-comparator
// binary-search model (input code vin_code, cmp = vin_code >= dac_code).
module tb_sar_adc_ctrl;
    import sar_pkg::*;

    localparam int N_BITS        = 8;
    localparam int SAMPLE_CYCLES = 4;
    localparam int SETTLE_CYCLES = 2;
`ifdef CMP_SYNC_EN
    localparam int SETTLE_EFF = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_EFF = SETTLE_CYCLES;
`endif
    localparam int LAT = SAMPLE_CYCLES + N_BITS * (SETTLE_EFF + 1) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmp_in;
    logic              sample;
    logic [N_BITS-1:0] dac_code;
    logic [N_BITS-1:0] vin_code = '0;
    sar_state_e        state_dbg;

    sar_adc_ctrl_if #(.N_BITS(N_BITS)) host ();

    sar_adc_ctrl #(
        .N_BITS        (N_BITS),
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_in    (cmp_in),
        .sample    (sample),
        .dac_code  (dac_code),
        .state_dbg (state_dbg),
        .host      (host.slave)
    );

    // Ideal comparator in front of the controller.
    assign cmp_in = (vin_code >= dac_code);

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [N_BITS-1:0] exp_q[$];
    logic [N_BITS-1:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Binary search: try each bit from the top, keep it if the input reaches it.
    function automatic void model_search(input logic [N_BITS-1:0] vin, output logic [N_BITS-1:0] code);
        logic [N_BITS-1:0] t;
        code = '0;
        exp_q.delete();
        for (int b = N_BITS - 1; b >= 0; b--) begin
            t = code | (N_BITS'(1) << b);
            exp_q.push_back(t);
            if (vin >= t) code = t;
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sample"}, 32'(sample), 0);
        check({tag, "_dac"}, 32'(dac_code), 0);
        check({tag, "_busy"}, 32'(host.busy), 0);
        check({tag, "_done"}, 32'(host.done), 0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // Cycle c = c-th negedge after the edge that samples start; done seen at c=LAT.
    task automatic run_conv(input logic [N_BITS-1:0] vin, input int pa, input int pb);
        logic [N_BITS-1:0] exp_res;
        logic [N_BITS-1:0] prev;
        int cyc, n_sample, busy_gap, extra_done, extra_busy, tail;
        bit seen_done;
        model_search(vin, exp_res);
        vin_code = vin;
        got_q.delete();
        prev = '0; cyc = 0; n_sample = 0; busy_gap = 0; seen_done = 0;
        @(negedge clk);
        host.start = 1'b1;
        while (!seen_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            host.start = (cyc == pa) || (cyc == pb);
            if (sample) n_sample++;
            if (!host.busy) busy_gap++;
            if (dac_code != prev && dac_code != '0) got_q.push_back(dac_code);
            prev = dac_code;
            if (host.done) seen_done = 1'b1;
        end
        host.start = 1'b0;
        check("done_seen", 32'(seen_done), 1);
        check("latency", 32'(cyc), 32'(LAT));
        check("result", 32'(host.result), 32'(exp_res));
        check("sample_cycles", 32'(n_sample), 32'(SAMPLE_CYCLES));
        check("busy_gap", 32'(busy_gap), 0);
        check("dac_len", 32'(got_q.size()), 32'(N_BITS));
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("dac_seq%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        @(negedge clk);
        check_idle_outputs("after_done");
        check("result_hold", 32'(host.result), 32'(exp_res));
        tail = (pa != 0) ? 40 : 2;
        extra_done = 0; extra_busy = 0;
        for (int i = 0; i < tail; i++) begin
            @(negedge clk);
            if (host.done) extra_done++;
            if (host.busy) extra_busy++;
        end
        check("no_extra_done", 32'(extra_done), 0);
        check("no_extra_busy", 32'(extra_busy), 0);
    endtask

    initial begin
        logic [N_BITS-1:0] exp_res;
        int last, ndone, idle_run, drained;
        host.start = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_result", 32'(host.result), 0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Directed conversions, including both rails
        run_conv(8'hA5, 0, 0);
        run_conv(8'h00, 0, 0);
        run_conv(8'hFF, 0, 0);

        // start held high: back-to-back conversions with one idle cycle
        vin_code = 8'h3C;
        model_search(8'h3C, exp_res);
        last = -1; ndone = 0; idle_run = 0;
        @(negedge clk);
        host.start = 1'b1;
        for (int cyc = 1; cyc <= 3 * (LAT + 1) + 5; cyc++) begin
            @(negedge clk);
            if (host.done) begin
                ndone++;
                check("held_result", 32'(host.result), 32'(exp_res));
                if (last >= 0) check("held_period", 32'(cyc - last), 32'(LAT + 1));
                last = cyc;
            end
            if (!host.busy) idle_run++;
            else if (idle_run != 0) begin
                check("held_idle", 32'(idle_run), 1);
                idle_run = 0;
            end
        end
        host.start = 1'b0;
        check("held_dones", 32'(ndone), 3);
        drained = 0;
        for (int i = 0; i < 2 * LAT && !drained; i++) begin
            @(negedge clk);
            if (!host.busy) drained = 1;
        end
        check("held_drain", 32'(drained), 1);

        // Reset in the middle of a conversion
        vin_code = 8'h5A;
        @(negedge clk);
        host.start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            host.start = 1'b0;
            if (cyc == 12) rst = 1'b1;
        end
        @(negedge clk);
        check_idle_outputs("mid_reset");
        check("mid_reset_result", 32'(host.result), 0);
        rst = 1'b0;
        run_conv(8'h5A, 0, 0);

        // start pulses while busy are dropped
        run_conv(8'h69, 5, 20);

        // Random input codes
        for (int i = 0; i < 6; i++)
            run_conv(N_BITS'($urandom_range(0, (1 << N_BITS) - 1)), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
